// File: rtl/draw_pkg.sv
// Shared types for the draw pixel-pair fetch path.
package draw_pkg;

  localparam int unsigned ADDR_W_DEF = 14;
  localparam int unsigned DATA_W_DEF = 8;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr_a;
    logic [ADDR_W_DEF-1:0] addr_b;
    logic [DATA_W_DEF-1:0] q_a;
    logic [DATA_W_DEF-1:0] q_b;
    logic                  last;
  } pix_pair_t;

  typedef logic [1:0] ser_state_e;

  localparam ser_state_e IDLE   = 2'd0;
  localparam ser_state_e SEND_A = 2'd1;
  localparam ser_state_e SEND_B = 2'd2;

endpackage

// File: rtl/pair_fifo.sv
// Small synchronous FIFO of pixel pairs; DEPTH must be a power of two so pointers wrap freely.
module pair_fifo
  import draw_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type T = pix_pair_t,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  T                 wdata,
  input  logic             pop,
  output T                 rdata,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  T                 mem_q [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage needs no reset: the count gates every read of it.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  no_underflow: assert property (@(posedge clk) disable iff (!reset) !(pop && empty));

endmodule

// File: rtl/draw_pair_fetch.sv
// Fetches even/odd pixel pairs from a dual-port memory and serialises them as a pixel stream.
module draw_pair_fetch
  import draw_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              addr_valid,
  output logic              addr_ready,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic              addr_last,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr_a,
  output logic [ADDR_W-1:0] mem_addr_b,
  input  logic [DATA_W-1:0] mem_q_a,
  input  logic [DATA_W-1:0] mem_q_b,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [DATA_W-1:0] pix_data,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              pix_last,
  output logic              done
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] q_a;
    logic [DATA_W-1:0] q_b;
    logic              last;
  } pair_t;

  logic              inflight_q;
  logic              last_seen_q;
  logic              done_q;
  logic [ADDR_W-1:0] cap_a_q;
  logic [ADDR_W-1:0] cap_b_q;
  logic              cap_last_q;
  ser_state_e        state_q;
  ser_state_e        state_d;

  logic              accept;
  logic              pop;
  pair_t             wdata;
  pair_t             head;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;

  // An in-flight read already owns a FIFO slot, so it counts against the credit.
  assign addr_ready = reset && !done_q && !last_seen_q &&
                      ((count + CNT_W'(inflight_q)) < CNT_W'(DEPTH));
  assign accept     = addr_valid && addr_ready;
  assign mem_en     = accept;
  assign mem_addr_a = addr_a;
  assign mem_addr_b = addr_b;

  always_comb begin
    wdata        = '0;
    wdata.addr_a = cap_a_q;
    wdata.addr_b = cap_b_q;
    wdata.q_a    = mem_q_a;
    wdata.q_b    = mem_q_b;
    wdata.last   = cap_last_q;
  end

  assign pop = (state_q == SEND_B) && pix_ready;

  pair_fifo #(
    .DEPTH (DEPTH),
    .T     (pair_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (inflight_q),
    .wdata (wdata),
    .pop   (pop),
    .rdata (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_q  <= 1'b0;
      last_seen_q <= 1'b0;
      done_q      <= 1'b0;
      cap_a_q     <= '0;
      cap_b_q     <= '0;
      cap_last_q  <= 1'b0;
      state_q     <= IDLE;
    end else begin
      inflight_q <= accept;
      if (accept) begin
        cap_a_q    <= addr_a;
        cap_b_q    <= addr_b;
        cap_last_q <= addr_last;
      end
      if (accept && addr_last) last_seen_q <= 1'b1;
      if (pop && head.last)    done_q      <= 1'b1;
      state_q <= state_d;
    end
  end

  // A pending push counts as "not empty" so the first pixel leaves two cycles after accept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!empty || inflight_q) state_d = SEND_A;
      SEND_A:  if (pix_ready) state_d = SEND_B;
      SEND_B:  if (pix_ready) state_d = ((count > CNT_W'(1)) || inflight_q) ? SEND_A : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pix_valid = 1'b0;
    pix_data  = '0;
    pix_addr  = '0;
    pix_last  = 1'b0;
    case (state_q)
      SEND_A: begin
        pix_valid = 1'b1;
        pix_data  = head.q_a;
        pix_addr  = head.addr_a;
      end
      SEND_B: begin
        pix_valid = 1'b1;
        pix_data  = head.q_b;
        pix_addr  = head.addr_b;
        pix_last  = head.last;
      end
      default: ;
    endcase
  end

  assign done = done_q;

  no_overflow: assert property (@(posedge clk) disable iff (!reset) !(inflight_q && full));

endmodule

// File: tb/tb_draw_pair_fetch.sv
// Randomised bench for draw_pair_fetch with an in-order pixel scoreboard and directed checks.
module tb_draw_pair_fetch;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              addr_valid = 1'b0;
  logic              addr_ready;
  logic [ADDR_W-1:0] addr_a = '0;
  logic [ADDR_W-1:0] addr_b = '0;
  logic              addr_last = 1'b0;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr_a;
  logic [ADDR_W-1:0] mem_addr_b;
  logic [DATA_W-1:0] mem_q_a = '0;
  logic [DATA_W-1:0] mem_q_b = '0;
  logic              pix_valid;
  logic              pix_ready = 1'b0;
  logic [DATA_W-1:0] pix_data;
  logic [ADDR_W-1:0] pix_addr;
  logic              pix_last;
  logic              done;

  draw_pair_fetch #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .addr_a     (addr_a),
    .addr_b     (addr_b),
    .addr_last  (addr_last),
    .mem_en     (mem_en),
    .mem_addr_a (mem_addr_a),
    .mem_addr_b (mem_addr_b),
    .mem_q_a    (mem_q_a),
    .mem_q_b    (mem_q_b),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .pix_addr   (pix_addr),
    .pix_last   (pix_last),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Memory model: mem[x] = x[7:0], one cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      mem_q_a <= mem_addr_a[7:0];
      mem_q_b <= mem_addr_b[7:0];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state: expected pixel stream plus pair-level bookkeeping.
  logic [ADDR_W-1:0] exp_addr[$];
  logic [DATA_W-1:0] exp_data[$];
  bit                exp_last[$];
  int                outstanding = 0;
  bit                done_m = 0;
  bit                last_seen_m = 0;
  bit                half = 0;
  bit                prev_stall = 0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [DATA_W-1:0] prev_data = '0;
  int                beats = 0;
  logic [ADDR_W-1:0] first_addr = '0;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_data;
  bit                e_last;

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_addr_ready", 32'(addr_ready), 32'(0));
      chk("rst_mem_en", 32'(mem_en), 32'(0));
      chk("rst_pix_valid", 32'(pix_valid), 32'(0));
      chk("rst_pix_data", 32'(pix_data), 32'(0));
      chk("rst_pix_addr", 32'(pix_addr), 32'(0));
      chk("rst_pix_last", 32'(pix_last), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      exp_addr.delete();
      exp_data.delete();
      exp_last.delete();
      outstanding = 0;
      done_m      = 0;
      last_seen_m = 0;
      half        = 0;
      prev_stall  = 0;
    end else begin
      chk("addr_ready", 32'(addr_ready),
          32'(!done_m && !last_seen_m && (outstanding < int'(DEPTH))));
      chk("mem_en", 32'(mem_en), 32'(addr_valid && addr_ready));
      if (mem_en) begin
        chk("mem_addr_a", 32'(mem_addr_a), 32'(addr_a));
        chk("mem_addr_b", 32'(mem_addr_b), 32'(addr_b));
      end
      chk("done", 32'(done), 32'(done_m));
      chk("occupancy_le_depth", 32'(outstanding <= int'(DEPTH)), 32'(1));
      if (outstanding == 0) chk("idle_no_valid", 32'(pix_valid), 32'(0));
      if (prev_stall) begin
        chk("hold_valid", 32'(pix_valid), 32'(1));
        chk("hold_addr", 32'(pix_addr), 32'(prev_addr));
        chk("hold_data", 32'(pix_data), 32'(prev_data));
      end
      if (pix_valid && pix_ready) begin
        beats++;
        if (beats == 1) first_addr = pix_addr;
        if (exp_addr.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat: got addr 0x%0h, expected no pixel (t=%0t)",
                   pix_addr, $time);
        end else begin
          e_addr = exp_addr.pop_front();
          e_data = exp_data.pop_front();
          e_last = exp_last.pop_front();
          chk("pix_addr", 32'(pix_addr), 32'(e_addr));
          chk("pix_data", 32'(pix_data), 32'(e_data));
          chk("pix_last", 32'(pix_last), 32'(e_last));
          if (e_last) done_m = 1;
          half = !half;
          if (!half) outstanding--;
        end
      end
      if (addr_valid && addr_ready) begin
        exp_addr.push_back(addr_a);
        exp_data.push_back(addr_a[7:0]);
        exp_last.push_back(1'b0);
        exp_addr.push_back(addr_b);
        exp_data.push_back(addr_b[7:0]);
        exp_last.push_back(addr_last);
        outstanding++;
        if (addr_last) last_seen_m = 1;
      end
      prev_stall = pix_valid && !pix_ready;
      prev_addr  = pix_addr;
      prev_data  = pix_data;
    end
  end

  task automatic drive_pair(input int n, input bit last);
    addr_a    = ADDR_W'(2 * n);
    addr_b    = ADDR_W'(2 * n + 1);
    addr_last = last;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    reset      = 1'b0;
    addr_valid = 1'b0;
    pix_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
    beats = 0;
  endtask

  // Streams npairs starting at pair index first; stops on done or after max_cyc cycles.
  task automatic run_region(input int first, input int npairs, input int rdy_pct,
                            input int max_cyc, output int cycles);
    int idx = 0;
    cycles = 0;
    while (cycles < max_cyc && !done) begin
      addr_valid = (idx < npairs);
      drive_pair(first + idx, idx == npairs - 1);
      pix_ready = (int'($urandom_range(99)) < rdy_pct);
      @(negedge clk);
      if (addr_valid && addr_ready) idx++;
      @(posedge clk);
      #1;
      cycles++;
    end
    addr_valid = 1'b0;
    pix_ready  = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int cyc;

    // Reset state, with upstream already offering a pair.
    reset      = 1'b0;
    addr_valid = 1'b1;
    pix_ready  = 1'b1;
    drive_pair(2688, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_addr_ready", 32'(addr_ready), 32'(0));
    chk("reset_pix_valid", 32'(pix_valid), 32'(0));
    addr_valid = 1'b0;
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Single pair: pixels two and three cycles after accept, then done.
    addr_valid = 1'b1;
    pix_ready  = 1'b1;
    drive_pair(2688, 1'b1);
    @(negedge clk);
    chk("single_accept", 32'(addr_ready), 32'(1));
    chk("single_mem_en", 32'(mem_en), 32'(1));
    @(posedge clk);
    #1;
    addr_valid = 1'b0;
    @(negedge clk);
    chk("single_t1_valid", 32'(pix_valid), 32'(0));
    chk("single_t1_mem_en", 32'(mem_en), 32'(0));
    @(negedge clk);
    chk("single_t2_valid", 32'(pix_valid), 32'(1));
    chk("single_t2_addr", 32'(pix_addr), 32'(5376));
    chk("single_t2_data", 32'(pix_data), 32'h00);
    chk("single_t2_last", 32'(pix_last), 32'(0));
    @(negedge clk);
    chk("single_t3_valid", 32'(pix_valid), 32'(1));
    chk("single_t3_addr", 32'(pix_addr), 32'(5377));
    chk("single_t3_data", 32'(pix_data), 32'h01);
    chk("single_t3_last", 32'(pix_last), 32'(1));
    @(negedge clk);
    chk("single_done", 32'(done), 32'(1));
    chk("single_t4_valid", 32'(pix_valid), 32'(0));

    // Back-pressure: exactly DEPTH pairs accepted, head held, then full drain.
    do_reset();
    pix_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      addr_valid = 1'b1;
      drive_pair(2688 + idx, 1'b0);
      @(negedge clk);
      if (addr_valid && addr_ready) idx++;
      @(posedge clk);
      #1;
    end
    chk("stall_accepted", 32'(idx), 32'(4));
    chk("stall_addr_ready", 32'(addr_ready), 32'(0));
    chk("stall_pix_addr", 32'(pix_addr), 32'(5376));
    chk("stall_pix_data", 32'(pix_data), 32'h00);
    addr_valid = 1'b0;
    pix_ready  = 1'b1;
    beats      = 0;
    repeat (20) @(posedge clk);
    #1;
    chk("stall_drained", 32'(beats), 32'(8));
    chk("stall_queue_empty", 32'(exp_addr.size()), 32'(0));

    // Full region at full rate.
    do_reset();
    run_region(2688, 128, 100, 2000, cyc);
    chk("full_done", 32'(done), 32'(1));
    chk("full_beats", 32'(beats), 32'(256));
    chk("full_first", 32'(first_addr), 32'(5376));
    chk("full_rate", 32'(cyc <= 262), 32'(1));
    chk("full_queue_empty", 32'(exp_addr.size()), 32'(0));

    // After done, further upstream offers are refused.
    addr_valid = 1'b1;
    drive_pair(2816, 1'b0);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      chk("post_done_ready", 32'(addr_ready), 32'(0));
      chk("post_done_mem_en", 32'(mem_en), 32'(0));
      chk("post_done_valid", 32'(pix_valid), 32'(0));
    end
    @(posedge clk);
    #1;
    addr_valid = 1'b0;

    // Full region with random back-pressure.
    do_reset();
    run_region(2688, 128, 50, 3000, cyc);
    chk("rand_done", 32'(done), 32'(1));
    chk("rand_beats", 32'(beats), 32'(256));
    chk("rand_queue_empty", 32'(exp_addr.size()), 32'(0));

    // Asynchronous reset while pixel b is pending with three pairs buffered.
    do_reset();
    pix_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      addr_valid = (idx < 3);
      drive_pair(2688 + idx, 1'b0);
      @(negedge clk);
      if (addr_valid && addr_ready) idx++;
      @(posedge clk);
      #1;
    end
    addr_valid = 1'b0;
    chk("mid_head_a", 32'(pix_addr), 32'(5376));
    pix_ready = 1'b1;
    @(posedge clk);
    #1;
    pix_ready = 1'b0;
    chk("mid_pending_b_valid", 32'(pix_valid), 32'(1));
    chk("mid_pending_b_addr", 32'(pix_addr), 32'(5377));
    #2;
    reset      = 1'b0;
    addr_valid = 1'b1;
    #1;
    chk("async_pix_valid", 32'(pix_valid), 32'(0));
    chk("async_pix_addr", 32'(pix_addr), 32'(0));
    chk("async_pix_data", 32'(pix_data), 32'(0));
    chk("async_addr_ready", 32'(addr_ready), 32'(0));
    chk("async_mem_en", 32'(mem_en), 32'(0));
    repeat (2) @(posedge clk);
    #3;
    addr_valid = 1'b0;
    reset      = 1'b1;
    @(posedge clk);
    #1;
    beats = 0;
    run_region(2688, 4, 100, 100, cyc);
    chk("restart_done", 32'(done), 32'(1));
    chk("restart_beats", 32'(beats), 32'(8));
    chk("restart_first", 32'(first_addr), 32'(5376));

    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/draw_pair_fetch.md
Name: draw_pair_fetch

Overview:
- Consumes the paired even/odd pixel address stream from the draw address counter: addr_a = {n,0}, addr_b = {n,1}.
- Reads both pixels in one cycle from an external dual-port ROM/RAM with 1-cycle read latency.
- Buffers each pixel pair in a small FIFO and serialises it to the downstream pixel writer as a single valid/ready stream: pixel a, then pixel b.
- Asserts a sticky done flag once the last pair has been fully delivered.

Parameters:
- ADDR_W, 14, width of pixel addresses
- DATA_W, 8, width of one pixel
- DEPTH, 4, FIFO entries (pixel pairs); power of two, ≥2

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- addr_valid  in  1  upstream address pair valid
- addr_ready  out  1  block can accept an address pair this cycle
- addr_a  in  ADDR_W  even pixel address
- addr_b  in  ADDR_W  odd pixel address
- addr_last  in  1  this pair is the final pair of the frame/region
- mem_en  out  1  read strobe to both memory ports
- mem_addr_a  out  ADDR_W  port A read address
- mem_addr_b  out  ADDR_W  port B read address
- mem_q_a  in  DATA_W  port A data, valid 1 cycle after mem_en
- mem_q_b  in  DATA_W  port B data, valid 1 cycle after mem_en
- pix_valid  out  1  pixel output valid
- pix_ready  in  1  downstream accepts pixel
- pix_data  out  DATA_W  pixel value
- pix_addr  out  ADDR_W  address of pix_data
- pix_last  out  1  final pixel of the region (b half of the last pair)
- done  out  1  sticky; all pixels of the last pair delivered

Behaviour:
- Reset values: addr_ready=0 during reset; mem_en=0; pix_valid=0; pix_data=0; pix_addr=0; pix_last=0; done=0. FIFO empty, in-flight flag clear, serializer in IDLE.
- Reset is asynchronous. Assertion mid-operation discards FIFO contents and any in-flight read. No pixel beat may appear until the next accepted address.
- Accept rule: addr_ready = !done && !last_seen && (count + inflight < DEPTH).
  - last_seen is set when a pair with addr_last=1 is accepted.
  - An accept occurs when addr_valid && addr_ready.
- Read issue: mem_en = accept. mem_addr_a/b are combinational copies of addr_a/b.
- Capture:
  - A register captures addr_a, addr_b, addr_last and sets inflight.
  - On the next cycle, {mem_q_a, mem_q_b, addrs, last} is written into the FIFO.
- The in-flight credit guarantees the FIFO is never written when full. Overflow is a design error and must be flagged with an assertion.
- Latency: accept in cycle T gives the earliest pix_valid in cycle T+2 (pixel a). Pixel b follows in T+3 if pix_ready is high.
- Throughput: 1 pixel per cycle sustained. Upstream is throttled to 1 pair per 2 cycles by credits.
- Serializer FSM:
  - IDLE: enter SEND_A when FIFO not empty.
  - SEND_A: pix_valid=1, data/addr = head.a. On pix_ready, go to SEND_B.
  - SEND_B: pix_valid=1, data/addr = head.b, pix_last = head.last. On pix_ready: pop the head; go to SEND_A if the FIFO still holds another entry (excluding the popped one), else IDLE.
- pix_valid must not drop and pix_data/addr must hold stable while pix_valid && !pix_ready.
- Simultaneous FIFO push and pop in the same cycle is legal. count is unchanged.
- done rises on the clock edge after the SEND_B beat with last=1 is accepted. It stays high until reset, and addr_ready stays 0.
- Pointers wrap modulo DEPTH. count spans 0..DEPTH (width clog2(DEPTH)+1).
- addr_a/addr_b values are passed through unmodified. No arithmetic is applied to addresses.

Decomposition:
- Shared package draw_pkg:
  - ADDR_W/DATA_W defaults
  - typedef pix_pair_t {addr_a, addr_b, q_a, q_b, last}
  - typedef ser_state_e {IDLE, SEND_A, SEND_B}
- One sub-module, pair_fifo: synchronous DEPTH-entry FIFO of pix_pair_t, with push/pop/count/empty/full and asynchronous active-low reset. The serializer FSM and credit logic stay in the top module.

Test Plan:
- Memory model mem[x]=x[7:0], upstream counter 2688..2815 (pairs 5376/5377 … 5630/5631), pix_ready=1 → 256 pixels in order 5376,5377,…,5631 with data 0x00,0x01,…,0xFF; pix_last only on 5631; done=1 one cycle after that beat.
- Single pair 5376/5377 accepted in cycle 10 → pix_valid in cycle 12 with addr 5376/data 0x00, cycle 13 with addr 5377/data 0x01; mem_en high only in cycle 10.
- pix_ready=0 for 20 cycles with upstream always valid → exactly DEPTH=4 pairs accepted, addr_ready=0 thereafter; pix_data/pix_addr held stable at 5376/0x00; releasing pix_ready drains 8 pixels in order with no loss or duplication.
- Random pix_ready toggling (50%) over the full 128-pair region → scoreboard matches the in-order stream; FIFO never overflows (assertion silent); count ≤ 4 at all times.
- Reset pulsed low mid-stream while SEND_B is pending with 3 entries buffered → all outputs return to reset values asynchronously; after release, the restarted counter's first pair 5376/5377 is the first delivered; no stale pixel appears.
- After done=1, upstream keeps addr_valid=1 → addr_ready stays 0, mem_en stays 0, pix_valid stays 0 for 50 cycles.
